load_store_unit: RTL and testbench

- MEM-stage initiator that drives the byte-addressed, little-endian data memory over a word-wide req/ack handshake.
- Accepts byte, half and word loads and stores from the pipeline.
- Issues only word-aligned memory transactions; sub-word stores use read-modify-write.
- Extends load data, stalls the pipeline while busy, and flags misaligned accesses and memory timeouts.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with word-aligned req/ack memory port
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic misaligned;
  logic aligned_req;
  logic busy;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    if (sz == 2'b01) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end else begin
      case (off)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  always_comb begin
    misaligned  = (req_size_i == 2'b01 && req_addr_i[0]) ||
                  (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) ||
                  (req_size_i == 2'b11);
    aligned_req = (state_q == IDLE) && req_valid_i && !misaligned;
    busy        = (state_q == RD) || (state_q == WR) || (state_q == RMW_RD) || (state_q == RMW_WR);
  end

  assign stall_o    = aligned_req || busy;
  assign misalign_o = (state_q == IDLE) && req_valid_i && misaligned;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (aligned_req) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          if (!req_write_i)             state_d = RD;
          else if (req_size_i == 2'b10) state_d = WR;
          else                          state_d = RMW_RD;
        end
      end
      RD, WR, RMW_RD, RMW_WR: begin
        // Each memory state raises its own request one cycle after entry,
        // which also guarantees a low cycle between back-to-back requests.
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = (state_q == WR) || (state_q == RMW_WR);
          mem_addr_d  = {addr_q[31:2], 2'b00};
          mem_wdata_d = wdata_q;
          cnt_d       = 8'd0;
        end else if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == RMW_RD) begin
            wdata_d = store_merge(mem_rdata_i, wdata_q, addr_q[1:0], size_q);
            state_d = RMW_WR;
          end else begin
            if (state_q == RD) rdata_d = load_extend(mem_rdata_i, addr_q[1:0], size_q, uns_q);
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// A small memory responder acks after a programmable delay and logs every transfer.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        stall_o, done_o, misalign_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_ack_i = 1'b0;

  int checks = 0;
  int failures = 0;

  logic        mem_init = 1'b1;
  logic        ack_en = 1'b1;
  logic        block_wr = 1'b0;
  int          ack_delay = 0;
  int          wcnt = 0;
  logic [31:0] mem [0:15];
  int          trace_n = 0;
  logic [31:0] tr_addr [0:63];
  logic        tr_we [0:63];
  logic [31:0] tr_wd [0:63];
  int          req_hi_cnt = 0;

  load_store_unit #(.TIMEOUT_CYCLES(63)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mem_req_o) req_hi_cnt <= req_hi_cnt + 1;
    if (mem_req_o && ack_en && !(block_wr && mem_we_o)) begin
      if (wcnt == ack_delay) begin
        mem_ack_i   <= 1'b1;
        mem_rdata_i <= mem[mem_addr_o[5:2]];
      end else begin
        mem_ack_i <= 1'b0;
        wcnt      <= wcnt + 1;
      end
    end else begin
      mem_ack_i <= 1'b0;
      wcnt      <= 0;
    end
  end

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[2] <= 32'h80FF1234;
    end else if (mem_req_o && mem_ack_i) begin
      tr_addr[trace_n] <= mem_addr_o;
      tr_we[trace_n]   <= mem_we_o;
      tr_wd[trace_n]   <= mem_wdata_o;
      trace_n          <= trace_n + 1;
      if (mem_we_o) mem[mem_addr_o[5:2]] <= mem_wdata_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int stalls);
    bit got;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = wr; req_size_i = sz;
    req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
    stalls = 0; got = 0; rd = 32'd0; er = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      #1;
      if (done_o) begin
        got = 1; rd = rdata_o; er = err_o;
      end else begin
        if (stall_o) stalls++;
        @(negedge clk_i);
      end
    end
    req_valid_i = 1'b0;
    check("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          st, t0, h0;
    bit          seen;

    #1;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_done_stall", {30'd0, done_o, stall_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    mem_init = 1'b0; rst_n_i = 1'b1;

    // 1: word load with ack two cycles after request
    ack_delay = 2; t0 = trace_n;
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, rd, er, st);
    check("t1_rdata", rd, 32'h80FF1234);
    check("t1_err", 32'(er), 32'd0);
    check("t1_stalls", 32'(st), 32'd5);
    check("t1_ntr", 32'(trace_n - t0), 32'd1);
    check("t1_addr", tr_addr[t0], 32'h8);
    check("t1_we", 32'(tr_we[t0]), 32'd0);
    @(negedge clk_i); #1;
    check("t1_done_pulse", 32'(done_o), 32'd0);

    // 2: sub-word loads, minimum latency
    ack_delay = 0;
    access(1'b0, 2'b00, 1'b0, 32'hA, 32'd0, rd, er, st);
    check("t2_sb", rd, 32'hFFFFFFFF);
    check("t2_lat_load", 32'(st), 32'd3);
    access(1'b0, 2'b00, 1'b1, 32'h9, 32'd0, rd, er, st);
    check("t2_ub", rd, 32'h00000012);
    access(1'b0, 2'b01, 1'b0, 32'hA, 32'd0, rd, er, st);
    check("t2_sh", rd, 32'hFFFF80FF);
    access(1'b0, 2'b01, 1'b1, 32'hA, 32'd0, rd, er, st);
    check("t2_uh", rd, 32'h000080FF);

    // 3: byte store via read-modify-write
    t0 = trace_n;
    access(1'b1, 2'b00, 1'b0, 32'hB, 32'h000000AB, rd, er, st);
    check("t3_lat_rmw", 32'(st), 32'd5);
    check("t3_store_rdata", rd, 32'd0);
    check("t3_ntr", 32'(trace_n - t0), 32'd2);
    check("t3_rd_addr", tr_addr[t0], 32'h8);
    check("t3_rd_we", 32'(tr_we[t0]), 32'd0);
    check("t3_wr_addr", tr_addr[t0+1], 32'h8);
    check("t3_wr_we", 32'(tr_we[t0+1]), 32'd1);
    check("t3_wr_data", tr_wd[t0+1], 32'hABFF1234);
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, rd, er, st);
    check("t3_readback", rd, 32'hABFF1234);

    // 4: misaligned requests are flagged and never reach memory
    h0 = req_hi_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h6;
    #1;
    check("t4_word_mis", 32'(misalign_o), 32'd1);
    check("t4_word_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    req_size_i = 2'b01; req_addr_i = 32'h3;
    #1;
    check("t4_half_mis", 32'(misalign_o), 32'd1);
    check("t4_half_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i); #1;
    check("t4_no_req", 32'(req_hi_cnt - h0), 32'd0);

    // 5: timeout with ack held low
    ack_en = 1'b0; h0 = req_hi_cnt;
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, rd, er, st);
    check("t5_req_cycles", 32'(req_hi_cnt - h0), 32'd63);
    check("t5_req_low", 32'(mem_req_o), 32'd0);
    check("t5_err", 32'(er), 32'd1);
    check("t5_rdata", rd, 32'd0);
    ack_en = 1'b1;

    // 6: async reset while the RMW write waits for ack
    block_wr = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'hB; req_wdata_i = 32'h55;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_i);
      if (mem_req_o && mem_we_o) seen = 1;
    end
    check("t6_reach_rmw_wr", 32'(seen), 32'd1);
    #1 rst_n_i = 1'b0;
    #1;
    check("t6_req_dropped", 32'(mem_req_o), 32'd0);
    check("t6_we_dropped", 32'(mem_we_o), 32'd0);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1; block_wr = 1'b0;
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, rd, er, st);
    check("t6_after_rst", rd, 32'hABFF1234);
    check("t6_err", 32'(er), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
